// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic CauseMisaligned = 1'b0;
    localparam logic CauseIllegal    = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRd
    } lsu_state_e;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 >= 3'b011;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size is encoded in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr);
        case (f3[1:0])
            2'b01:   return addr[0];
            2'b10:   return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] addr);
        case (f3[1:0])
            2'b00:   return 4'b0001 << addr;
            2'b01:   return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word lane from a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        unique case (addr_i)
            2'b00: byte_lane = rdata_i[7:0];
            2'b01: byte_lane = rdata_i[15:8];
            2'b10: byte_lane = rdata_i[23:16];
            2'b11: byte_lane = rdata_i[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {24'h000000, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data_o = {16'h0000, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: issues one word-aligned request per op and returns aligned loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic            ex_is_load_i,
    input  logic            ex_is_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic [4:0]      ex_rd_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_wstrb_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            lsu_err_o,
    output logic            lsu_err_cause_o,
    output logic [XLEN-1:0] lsu_err_addr_o
);

    lsu_state_e state_q, state_d;

    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            err_q, err_d;
    logic            err_cause_q, err_cause_d;
    logic [XLEN-1:0] err_addr_q, err_addr_d;

    logic            op_store;
    logic            op_illegal;
    logic            op_misaligned;
    logic [XLEN-1:0] load_data;

    assign op_store      = ex_is_store_i & ~ex_is_load_i;
    assign op_illegal    = f3_illegal(op_store, ex_funct3_i);
    assign op_misaligned = misaligned(ex_funct3_i, ex_addr_i[1:0]);

    lsu_load_align u_load_align (
        .rdata_i  (mem_rdata_i),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;

        unique case (state_q)
            StIdle: begin
                if (ex_valid_i) begin
                    if (op_illegal || op_misaligned) begin
                        // Faulting ops never reach memory; the unit stays ready.
                        err_d       = 1'b1;
                        err_cause_d = op_illegal ? CauseIllegal : CauseMisaligned;
                        err_addr_d  = ex_addr_i;
                    end else begin
                        state_d  = StReq;
                        addr_d   = ex_addr_i;
                        funct3_d = ex_funct3_i;
                        rd_d     = ex_rd_i;
                        we_d     = op_store;
                        wstrb_d  = op_store ? store_strb(ex_funct3_i, ex_addr_i[1:0]) : 4'b0000;
                        wdata_d  = op_store ? store_data(ex_funct3_i, ex_wdata_i) : '0;
                    end
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? StIdle : StWaitRd;
                end
            end
            StWaitRd: begin
                if (mem_rvalid_i) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_data;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            err_cause_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Memory-side outputs are forced to zero whenever no request is outstanding.
    assign ex_ready_o      = (state_q == StIdle);
    assign mem_req_o       = (state_q == StReq);
    assign mem_we_o        = mem_req_o & we_q;
    assign mem_addr_o      = mem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wstrb_o     = mem_req_o ? wstrb_q : 4'b0000;
    assign mem_wdata_o     = mem_req_o ? wdata_q : '0;
    assign wb_valid_o      = wb_valid_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;
    assign lsu_err_o       = err_q;
    assign lsu_err_cause_o = err_cause_q;
    assign lsu_err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with hand-written reset and back-to-back sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err, lsu_err_cause;
    logic [31:0] lsu_err_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .ex_is_load_i    (ex_is_load),
        .ex_is_store_i   (ex_is_store),
        .ex_funct3_i     (ex_funct3),
        .ex_addr_i       (ex_addr),
        .ex_wdata_i      (ex_wdata),
        .ex_rd_i         (ex_rd),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wstrb_o     (mem_wstrb),
        .mem_wdata_o     (mem_wdata),
        .mem_gnt_i       (mem_gnt),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .wb_valid_o      (wb_valid),
        .wb_rd_o         (wb_rd),
        .wb_data_o       (wb_data),
        .lsu_err_o       (lsu_err),
        .lsu_err_cause_o (lsu_err_cause),
        .lsu_err_addr_o  (lsu_err_addr)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        err;
        logic        cause;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_store = st;
        ex_is_load  = ~st;
        ex_funct3   = f3;
        ex_addr     = addr;
        ex_wdata    = wdata;
        ex_rd       = rd;
    endtask

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        ex_is_store = 1'b0;
        ex_is_load  = 1'b0;
    endtask

    // Inputs change and outputs are sampled at negedge, away from the active edge.
    task automatic run_vec(input int i, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d ex_ready", i), {31'd0, ex_ready}, 32'd1);
        present(v.st, v.f3, v.addr, v.wdata, v.rd);
        @(negedge clk);
        idle_inputs();
        if (v.err) begin
            chk($sformatf("v%0d lsu_err", i), {31'd0, lsu_err}, 32'd1);
            chk($sformatf("v%0d err_cause", i), {31'd0, lsu_err_cause}, {31'd0, v.cause});
            chk($sformatf("v%0d err_addr", i), lsu_err_addr, v.addr);
            chk($sformatf("v%0d no mem_req", i), {31'd0, mem_req}, 32'd0);
        end else begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                if (c > 0) @(negedge clk);
                chk($sformatf("v%0d mem_req c%0d", i, c), {31'd0, mem_req}, 32'd1);
                chk($sformatf("v%0d mem_addr c%0d", i, c), mem_addr, v.maddr);
            end
            chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.st});
            if (v.st) begin
                chk($sformatf("v%0d wstrb", i), {28'd0, mem_wstrb}, {28'd0, v.wstrb});
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.mwdata);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk($sformatf("v%0d req dropped", i), {31'd0, mem_req}, 32'd0);
            chk($sformatf("v%0d ready after gnt", i), {31'd0, ex_ready}, {31'd0, v.st});
            if (!v.st) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
                chk($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, 32'd1);
                chk($sformatf("v%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, v.rd});
                chk($sformatf("v%0d wb_data", i), wb_data, v.wbdata);
                @(negedge clk);
                chk($sformatf("v%0d wb_valid pulse", i), {31'd0, wb_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        idle_inputs();
        ex_funct3  = 3'b000;
        ex_addr    = 32'h0;
        ex_wdata   = 32'h0;
        ex_rd      = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        //           st    f3      addr        wdata         rd     rdata         dly err cause maddr        strb     mwdata        wbdata
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0,  32'h0,        3, 1'b0, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0,  32'h0,        0, 1'b0, 1'b0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b1, 3'b001, 32'h206, 32'h1234ABCD, 5'd0,  32'h0,        1, 1'b0, 1'b0, 32'h204, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[3]  = '{1'b0, 3'b000, 32'h301, 32'h0,        5'd5,  32'h000080FF, 0, 1'b0, 1'b0, 32'h300, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{1'b0, 3'b100, 32'h301, 32'h0,        5'd6,  32'h000080FF, 0, 1'b0, 1'b0, 32'h300, 4'b0000, 32'h0,        32'h00000080};
        vecs[5]  = '{1'b0, 3'b001, 32'h402, 32'h0,        5'd7,  32'h7FFF1234, 1, 1'b0, 1'b0, 32'h400, 4'b0000, 32'h0,        32'h00007FFF};
        vecs[6]  = '{1'b0, 3'b001, 32'h400, 32'h0,        5'd8,  32'h00009ABC, 0, 1'b0, 1'b0, 32'h400, 4'b0000, 32'h0,        32'hFFFF9ABC};
        vecs[7]  = '{1'b0, 3'b101, 32'h400, 32'h0,        5'd9,  32'h00009ABC, 2, 1'b0, 1'b0, 32'h400, 4'b0000, 32'h0,        32'h00009ABC};
        vecs[8]  = '{1'b0, 3'b010, 32'h500, 32'h0,        5'd0,  32'hCAFEF00D, 0, 1'b0, 1'b0, 32'h500, 4'b0000, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1'b0, 3'b010, 32'h102, 32'h0,        5'd1,  32'h0,        0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'b111, 32'h010, 32'h0,        5'd1,  32'h0,        0, 1'b1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 3'b011, 32'h001, 32'h0,        5'd0,  32'h0,        0, 1'b1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};

        @(negedge clk);
        @(negedge clk);
        chk("reset ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset lsu_err", {31'd0, lsu_err}, 32'd0);
        chk("reset wb_data", wb_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Misaligned SH: cause 0.
        @(negedge clk);
        present(1'b1, 3'b001, 32'h101, 32'h0, 5'd0);
        @(negedge clk);
        idle_inputs();
        chk("sh misalign err", {31'd0, lsu_err}, 32'd1);
        chk("sh misalign cause", {31'd0, lsu_err_cause}, 32'd0);

        // Error then a store accepted in the very next cycle.
        @(negedge clk);
        present(1'b0, 3'b010, 32'h102, 32'h0, 5'd3);
        @(negedge clk);
        chk("err next lsu_err", {31'd0, lsu_err}, 32'd1);
        chk("err next ex_ready", {31'd0, ex_ready}, 32'd1);
        present(1'b1, 3'b010, 32'h700, 32'h11223344, 5'd0);
        @(negedge clk);
        idle_inputs();
        chk("err next pulse end", {31'd0, lsu_err}, 32'd0);
        chk("err next mem_req", {31'd0, mem_req}, 32'd1);
        chk("err next mem_addr", mem_addr, 32'h700);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;

        // Reset while a request is pending: mem_req drops without a clock edge.
        @(negedge clk);
        present(1'b0, 3'b010, 32'h600, 32'h0, 5'd4);
        @(negedge clk);
        idle_inputs();
        chk("rst req mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst req async drop", {31'd0, mem_req}, 32'd0);
        chk("rst req ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in WAIT_RD, then a late rvalid.
        @(negedge clk);
        present(1'b0, 3'b010, 32'h600, 32'h0, 5'd4);
        @(negedge clk);
        idle_inputs();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst wait ex_ready", {31'd0, ex_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rst late wb_valid c%0d", c), {31'd0, wb_valid}, 32'd0);
            chk($sformatf("rst late wb_data c%0d", c), wb_data, 32'h0);
            chk($sformatf("rst late ex_ready c%0d", c), {31'd0, ex_ready}, 32'd1);
            chk($sformatf("rst late mem_req c%0d", c), {31'd0, mem_req}, 32'd0);
            @(negedge clk);
        end

        // Back-to-back: LH, then SH accepted in the cycle wb_valid pulses.
        present(1'b0, 3'b001, 32'h402, 32'h0, 5'd12);
        @(negedge clk);
        idle_inputs();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7FFF1234;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("b2b wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b wb_data", wb_data, 32'h00007FFF);
        chk("b2b wb_rd", {27'd0, wb_rd}, 32'd12);
        chk("b2b ex_ready", {31'd0, ex_ready}, 32'd1);
        present(1'b1, 3'b001, 32'h402, 32'h00005555, 5'd0);
        @(negedge clk);
        idle_inputs();
        chk("b2b sh mem_req", {31'd0, mem_req}, 32'd1);
        chk("b2b sh mem_addr", mem_addr, 32'h400);
        chk("b2b sh wstrb", {28'd0, mem_wstrb}, 32'hC);
        chk("b2b sh wdata", mem_wdata, 32'h55555555);
        chk("b2b wb_valid ends", {31'd0, wb_valid}, 32'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("b2b sh done", {31'd0, ex_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the execute ALU. It takes the ALU result as the effective address for RV32I loads and stores and issues one word-aligned request to the data memory. Loads are byte-lane extracted, sign- or zero-extended and returned to writeback; stores get byte strobes. A request/grant/response handshake with the memory lets the unit stall execute for multi-cycle memory.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `ex_valid` input 1: execute presents a memory op this cycle.
- `ex_ready` output 1: unit can accept an op. Equals `state==IDLE`.
- `ex_is_load` input 1: the op is a load.
- `ex_is_store` input 1: the op is a store. Exactly one of `ex_is_load`/`ex_is_store` is high when `ex_valid` is high.
- `ex_funct3` input 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `ex_addr` input 32: effective address (ALU result).
- `ex_wdata` input 32: rs2 value for stores.
- `ex_rd` input 5: load destination register.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_wstrb` output 4: byte-enable strobes.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_gnt` input 1: memory accepted the request.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 32: read word.
- `wb_valid` output 1: one-cycle pulse, load result ready.
- `wb_rd` output 5: destination register.
- `wb_data` output 32: extended load data.
- `lsu_err` output 1: one-cycle error pulse.
- `lsu_err_cause` output 1: 0 = misaligned, 1 = illegal funct3.
- `lsu_err_addr` output 32: faulting address.

## Operation
- FSM states: IDLE, REQ, WAIT_RD.
- **Accept:** an op is accepted when `ex_valid && ex_ready`. Address, funct3, rd, data and direction are latched.
- **Error check at accept:**
  - Misaligned: half access with `addr[0]==1`, or word access with `addr[1:0]!=0`.
  - Illegal funct3: load funct3 ∈ {011,110,111}; store funct3 ≥ 011.
  - On error: no memory request. `lsu_err` pulses the next cycle with the latched address. FSM stays in IDLE. Illegal funct3 takes priority over misalignment.
- **Valid op:** IDLE→REQ.
- **REQ state:**
  - `mem_req=1`. `mem_addr`/`mem_we`/`mem_wstrb`/`mem_wdata` are held stable until `mem_gnt`.
  - Store + gnt → IDLE.
  - Load + gnt → WAIT_RD.
- **WAIT_RD state:** on `mem_rvalid`, register `wb_data`/`wb_rd`, pulse `wb_valid` the next cycle, and go to IDLE.
- **Store strobes:**
  - SB: `4'b0001<<addr[1:0]`.
  - SH: `4'b0011<<{addr[1],1'b0}`.
  - SW: `4'b1111`.
- **Store data:** SB replicates the byte 4×, SH replicates the half 2×, SW passes through.
- **Load extraction:**
  - Byte = `rdata[8*addr[1:0] +: 8]`; half = `rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads to `rd=0` still access memory and still pulse `wb_valid`. Writeback discards them.
- `mem_rvalid` outside WAIT_RD is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing
- **Reset:** all outputs are 0 except `ex_ready`, which is 1 because state is IDLE. Every register is cleared asynchronously.
- **Reset mid-operation:** FSM goes to IDLE, `mem_req` drops immediately, and the pending load is dropped with no `wb_valid`. A late `mem_rvalid` after reset is ignored.
- **Load latency:** accept at cycle N → `mem_req` at N+1 → gnt at G ≥ N+1 → rvalid at R ≥ G+1 → `wb_valid` at R+1. Minimum total is 3 cycles.
- **Store latency:** accept at N → `mem_req` at N+1 → IDLE and `ex_ready=1` the cycle after gnt. Minimum total is 2 cycles.
- **Back-to-back:** the next op may be accepted in the same cycle that `wb_valid` pulses.
- **Error timing:** error at accept N → `lsu_err` at N+1. `ex_ready` stays 1, so the next op can be accepted at N+1.
- **Outputs:** `mem_*`, `wb_*` and `lsu_err*` are all registered or driven from state. There are no combinational paths from `mem_*` inputs to outputs.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum {IDLE, REQ, WAIT_RD}.
  - Error-cause constants.
- Sub-module `lsu_load_align`: combinational lane extraction and extension (inputs `rdata`, `addr[1:0]`, `funct3`). It is instantiated once, on the WAIT_RD capture path.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, gnt held low 3 cycles → `mem_req` held 3 cycles with `mem_addr=0x100`, `wstrb=1111`. IDLE one cycle after gnt.
- SB addr=0x203, wdata=0x000000A5 → `mem_addr=0x200`, `wstrb=1000`, `wdata=0xA5A5A5A5`.
- LB addr=0x301 with `rdata=0x0000_80FF`, rd=5 → `wb_valid` with `wb_rd=5`, `wb_data=0xFFFFFF80`. LBU on the same input gives 0x00000080. The `wb_valid` pulse arrives exactly one cycle after rvalid.
- LW addr=0x102 → `lsu_err=1`, cause=0, `lsu_err_addr=0x102`, no `mem_req`. Load funct3=111 → cause=1.
- Reset in WAIT_RD, then rvalid 2 cycles later → no `wb_valid`, `ex_ready=1`, and all outputs at reset values.
- Back-to-back LH addr=0x402 (rdata=0x7FFF1234 → `wb_data=0x00007FFF`) then SH accepted the same cycle `wb_valid` pulses → SH `mem_req` starts the next cycle.
